// File: rtl/fb_pkg.sv
// Shared widths and fill-engine state encoding for the frame-buffer write path.
// No logic; types and defaults only.
// Imported by fb_wr_fifo and fb_write_arbiter.
package fb_pkg;

  localparam int FB_ADDR_W     = 15;
  localparam int FB_DATA_W     = 6;
  localparam int FB_FIFO_DEPTH = 4;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_t;

endpackage

// File: rtl/fb_wr_fifo.sv
// Synchronous FIFO holding CPU pixel writes {addr, data}.
// Latency: a pushed entry is visible at the head one edge after the push.
// Backpressure: full when count == DEPTH; pushes while full and pops while empty are ignored.
module fb_wr_fifo
  import fb_pkg::*;
#(
  parameter int AW    = FB_ADDR_W,
  parameter int DW    = FB_DATA_W,
  parameter int DEPTH = FB_FIFO_DEPTH,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [AW-1:0] push_addr,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [AW-1:0] pop_addr,
  output logic [DW-1:0] pop_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [AW+DW-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  assign {pop_addr, pop_data} = mem[rd_ptr];

  // Storage array; contents are don't-care until pointed at, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= {push_addr, push_data};
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fb_write_arbiter.sv
// Merges queued CPU pixel writes and an optional rectangle-fill engine onto one frame-buffer write port.
// Latency: 2 edges from CPU strobe to fb_we when uncontended; fill pixels issue one edge after grant.
// Backpressure: cpu_full stalls the bus; writes arriving while full are dropped and flagged in cpu_ovf.
// Fill engine present only when FB_ARB_FILL_EN is defined.
module fb_write_arbiter
  import fb_pkg::*;
#(
  parameter int ADDR_W     = FB_ADDR_W,
  parameter int DATA_W     = FB_DATA_W,
  parameter int FIFO_DEPTH = FB_FIFO_DEPTH,
  localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_data,
  output logic              cpu_full,
  output logic              cpu_ovf,
  input  logic              fill_start,
  input  logic [ADDR_W-1:0] fill_base,
  input  logic [ADDR_W-1:0] fill_len,
  input  logic [DATA_W-1:0] fill_color,
  output logic              fill_busy,
  output logic              fill_done,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [DATA_W-1:0] fb_data
);

  logic              fifo_empty;
  logic [ADDR_W-1:0] q_addr;
  logic [DATA_W-1:0] q_data;
  logic [CNT_W-1:0]  fifo_count_unused;
  logic              grant_cpu;
  logic              grant_fill;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  fb_wr_fifo #(
    .AW    (ADDR_W),
    .DW    (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (cpu_we && !cpu_full),
    .push_addr (cpu_addr),
    .push_data (cpu_data),
    .pop       (grant_cpu),
    .pop_addr  (q_addr),
    .pop_data  (q_data),
    .full      (cpu_full),
    .empty     (fifo_empty),
    .count     (fifo_count_unused)
  );

  // Overflow flag sticks until reset so software can detect lost pixels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_ovf <= 1'b0;
    end else if (cpu_we && cpu_full) begin
      cpu_ovf <= 1'b1;
    end
  end

`ifdef FB_ARB_FILL_EN
  fill_state_t       state;
  logic [ADDR_W-1:0] fill_addr;
  logic [ADDR_W-1:0] fill_rem;
  logic [DATA_W-1:0] fill_col;
  logic              rr_cpu;
  logic              done_pend;
  logic              fill_req;

  assign fill_req   = (state == FILL);
  assign fill_busy  = fill_req;
  assign grant_cpu  = !fifo_empty && (!fill_req || rr_cpu);
  assign grant_fill = fill_req && !grant_cpu;
  assign wr_addr    = grant_cpu ? q_addr : fill_addr;
  assign wr_data    = grant_cpu ? q_data : fill_col;

  // Fill FSM; done is delayed one cycle so it follows the last pixel's fb_we.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      fill_addr <= '0;
      fill_rem  <= '0;
      fill_col  <= '0;
      done_pend <= 1'b0;
      fill_done <= 1'b0;
    end else begin
      fill_done <= done_pend;
      done_pend <= 1'b0;
      case (state)
        IDLE: begin
          if (fill_start) begin
            if (fill_len != '0) begin
              state     <= FILL;
              fill_addr <= fill_base;
              fill_rem  <= fill_len;
              fill_col  <= fill_color;
            end else begin
              fill_done <= 1'b1;
            end
          end
        end
        FILL: begin
          if (grant_fill) begin
            fill_addr <= fill_addr + 1'b1;
            fill_rem  <= fill_rem - 1'b1;
            if (fill_rem == ADDR_W'(1)) begin
              state     <= IDLE;
              done_pend <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Round-robin pointer: after any grant, favour the other requester next time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_cpu <= 1'b1;
    end else if (grant_cpu) begin
      rr_cpu <= 1'b0;
    end else if (grant_fill) begin
      rr_cpu <= 1'b1;
    end
  end
`else
  logic fill_inputs_unused;

  assign fill_inputs_unused = ^{fill_start, fill_base, fill_len, fill_color};
  assign fill_busy          = 1'b0;
  assign fill_done          = 1'b0;
  assign grant_cpu          = !fifo_empty;
  assign grant_fill         = 1'b0;
  assign wr_addr            = q_addr;
  assign wr_data            = q_data;
`endif

  // Registered write port; address/data hold their last value on idle cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fb_we   <= 1'b0;
      fb_addr <= '0;
      fb_data <= '0;
    end else begin
      fb_we <= grant_cpu || grant_fill;
      if (grant_cpu || grant_fill) begin
        fb_addr <= wr_addr;
        fb_data <= wr_data;
      end
    end
  end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Randomised and directed bench with a queue-based reference model and scoreboard.
// Expectations for fill behaviour follow FB_ARB_FILL_EN, same as the design.
// Model steps on the rising edge; monitor compares on the falling edge.
module tb_fb_write_arbiter;
  localparam int AW    = 15;
  localparam int DW    = 6;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_data = '0;
  logic          cpu_full, cpu_ovf;
  logic          fill_start = 1'b0;
  logic [AW-1:0] fill_base = '0;
  logic [AW-1:0] fill_len = '0;
  logic [DW-1:0] fill_color = '0;
  logic          fill_busy, fill_done;
  logic          fb_we;
  logic [AW-1:0] fb_addr;
  logic [DW-1:0] fb_data;

  fb_write_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
    .cpu_full(cpu_full), .cpu_ovf(cpu_ovf),
    .fill_start(fill_start), .fill_base(fill_base), .fill_len(fill_len), .fill_color(fill_color),
    .fill_busy(fill_busy), .fill_done(fill_done),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data)
  );

  always #5 clk = ~clk;

`ifdef FB_ARB_FILL_EN
  localparam bit FILL_ON = 1'b1;
`else
  localparam bit FILL_ON = 1'b0;
`endif

  int n_err = 0;
  int n_chk = 0;
  int n_wr = 0;
  int n_done = 0;
  bit saw_full = 1'b0;
  logic [AW-1:0] log_a[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Reference model: queue for CPU writes, remaining-pixel count for the fill.
  wr_t m_q[$];
  wr_t sb[$];
  int  m_rem = 0;
  logic [AW-1:0] m_faddr = '0;
  logic [DW-1:0] m_fcol = '0;
  bit  m_pref_cpu = 1'b1;
  bit  m_ovf = 1'b0, m_done_pend = 1'b0, m_done = 1'b0, m_we = 1'b0;
  wr_t m_last = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete(); sb.delete();
      m_rem = 0; m_faddr = '0; m_fcol = '0; m_pref_cpu = 1'b1;
      m_ovf = 1'b0; m_done_pend = 1'b0; m_done = 1'b0; m_we = 1'b0; m_last = '0;
    end else begin
      bit was_full, was_busy, cpu_r, fill_r, g_cpu, g_fill, dp;
      wr_t w;
      was_full = (m_q.size() == DEPTH);
      was_busy = (m_rem > 0);
      cpu_r    = (m_q.size() > 0);
      fill_r   = FILL_ON && was_busy;
      g_cpu    = (cpu_r && fill_r) ? m_pref_cpu : cpu_r;
      g_fill   = fill_r && !g_cpu;
      dp       = 1'b0;
      m_we     = g_cpu || g_fill;
      if (g_cpu) begin
        w = m_q.pop_front();
        sb.push_back(w); m_last = w; m_pref_cpu = 1'b0;
      end else if (g_fill) begin
        w.a = m_faddr; w.d = m_fcol;
        sb.push_back(w); m_last = w; m_pref_cpu = 1'b1;
        m_faddr = m_faddr + 1'b1;
        m_rem--;
        if (m_rem == 0) dp = 1'b1;
      end
      m_done = m_done_pend;
      if (FILL_ON && fill_start && !was_busy) begin
        if (fill_len == '0) m_done = 1'b1;
        else begin
          m_rem = int'(fill_len); m_faddr = fill_base; m_fcol = fill_color;
        end
      end
      m_done_pend = dp;
      if (cpu_we) begin
        if (was_full) m_ovf = 1'b1;
        else m_q.push_back({cpu_addr, cpu_data});
      end
    end
  end

  // Monitor: pops the scoreboard on every fb_we and checks status outputs.
  wr_t mw;
  always @(negedge clk) begin
    if (rst_n) begin
      chk("fb_we", fb_we, m_we);
      if (fb_we) begin
        n_wr++;
        log_a.push_back(fb_addr);
        if (sb.size() == 0) begin
          chk("sb_unexpected_write", 1, 0);
        end else begin
          mw = sb.pop_front();
          chk("fb_addr", fb_addr, mw.a);
          chk("fb_data", fb_data, mw.d);
        end
      end else begin
        chk("fb_addr_hold", fb_addr, m_last.a);
        chk("fb_data_hold", fb_data, m_last.d);
      end
      if (cpu_full) saw_full = 1'b1;
      if (fill_done) n_done++;
      chk("cpu_full", cpu_full, m_q.size() == DEPTH);
      chk("cpu_ovf", cpu_ovf, m_ovf);
      chk("fill_busy", fill_busy, m_rem > 0);
      chk("fill_done", fill_done, m_done);
    end
  end

  task automatic drv(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                     input bit fs, input logic [AW-1:0] fb, input logic [AW-1:0] fl,
                     input logic [DW-1:0] fc);
    cpu_we = we; cpu_addr = a; cpu_data = d;
    fill_start = fs; fill_base = fb; fill_len = fl; fill_color = fc;
    @(negedge clk);
    cpu_we = 1'b0; fill_start = 1'b0;
  endtask

  task automatic drain(input string nm);
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (m_q.size() == 0 && m_rem == 0 && sb.size() == 0 && !m_done_pend && !m_done && !m_we) begin
        idle = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk({nm, "_drain"}, idle, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int d0, w0;
    logic [AW-1:0] exp_a[$];
    logic [AW-1:0] prev;
    bit ord_ok;

    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_fb_we", fb_we, 0);
    chk("rst_fb_addr", fb_addr, 0);
    chk("rst_fb_data", fb_data, 0);
    chk("rst_cpu_full", cpu_full, 0);
    chk("rst_cpu_ovf", cpu_ovf, 0);
    chk("rst_fill_busy", fill_busy, 0);
    chk("rst_fill_done", fill_done, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single write: visible exactly two edges after the strobe is sampled.
    w0 = n_wr;
    drv(1, 15'h0123, 6'h2A, 0, '0, '0, '0);
    chk("single_early", fb_we, 0);
    @(negedge clk);
    chk("single_we", fb_we, 1);
    chk("single_addr", fb_addr, 15'h0123);
    chk("single_data", fb_data, 6'h2A);
    @(negedge clk);
    chk("single_once", fb_we, 0);
    drain("single");
    chk("single_count", n_wr - w0, 1);

    // Fill wrapping past the top of the address space.
    log_a.delete(); d0 = n_done;
    drv(0, '0, '0, 1, 15'h7FFE, 15'd4, 6'h15);
    drain("wrap");
    exp_a.delete();
    if (FILL_ON) exp_a = '{15'h7FFE, 15'h7FFF, 15'h0000, 15'h0001};
    chk("wrap_count", log_a.size(), exp_a.size());
    chk("wrap_done", n_done - d0, FILL_ON ? 1 : 0);
    if (log_a.size() == exp_a.size())
      foreach (exp_a[i]) chk($sformatf("wrap_addr%0d", i), log_a[i], exp_a[i]);

    // Contention: fill of 8 and 4 CPU writes starting together.
    log_a.delete();
    drv(1, 15'h0500, 6'h11, 1, 15'h0100, 15'd8, 6'h03);
    for (int i = 1; i < 4; i++) drv(1, 15'h0500 + 15'(i), 6'h11, 0, '0, '0, '0);
    drain("cont");
    exp_a.delete();
    for (int i = 0; i < 4; i++) begin
      exp_a.push_back(15'h0500 + 15'(i));
      if (FILL_ON) exp_a.push_back(15'h0100 + 15'(i));
    end
    if (FILL_ON) for (int j = 4; j < 8; j++) exp_a.push_back(15'h0100 + 15'(j));
    chk("cont_count", log_a.size(), FILL_ON ? 12 : 4);
    if (log_a.size() == exp_a.size())
      foreach (exp_a[i]) chk($sformatf("cont_addr%0d", i), log_a[i], exp_a[i]);

    // Zero-length fill: done next cycle, no writes, no busy.
    drv(0, '0, '0, 1, 15'h0040, 15'd0, 6'h01);
    chk("zlen_done", fill_done, FILL_ON);
    chk("zlen_we", fb_we, 0);
    chk("zlen_busy", fill_busy, 0);
    @(negedge clk);
    chk("zlen_done_off", fill_done, 0);

    // Second fill_start while busy is ignored.
    w0 = n_wr; d0 = n_done;
    drv(0, '0, '0, 1, 15'h0300, 15'd5, 6'h07);
    @(negedge clk);
    drv(0, '0, '0, 1, 15'h0700, 15'd3, 6'h09);
    drain("busy");
    chk("busy_count", n_wr - w0, FILL_ON ? 5 : 0);
    chk("busy_done", n_done - d0, FILL_ON ? 1 : 0);

    // Overflow: long fill halves CPU drain rate while CPU writes every cycle.
    log_a.delete(); saw_full = 1'b0;
    drv(0, '0, '0, 1, 15'h0200, 15'd30, 6'h0C);
    for (int i = 0; i < 10; i++) drv(1, 15'h0600 + 15'(i), DW'(i), 0, '0, '0, '0);
    drain("ovf");
    chk("ovf_flag", cpu_ovf, FILL_ON);
    chk("ovf_saw_full", saw_full, FILL_ON);
    ord_ok = 1'b1; prev = '0;
    foreach (log_a[i]) if (log_a[i] >= 15'h0600 && log_a[i] < 15'h0700) begin
      if (prev != '0 && log_a[i] <= prev) ord_ok = 1'b0;
      prev = log_a[i];
    end
    chk("ovf_order", ord_ok, 1);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      cpu_we     = ($urandom_range(0, 1) == 1);
      cpu_addr   = AW'($urandom);
      cpu_data   = DW'($urandom);
      fill_start = ($urandom_range(0, 15) == 0);
      fill_base  = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(32'h7FF0, 32'h7FFF)) : AW'($urandom);
      fill_len   = AW'($urandom_range(0, 9));
      fill_color = DW'($urandom);
      @(negedge clk);
    end
    cpu_we = 1'b0; fill_start = 1'b0;
    drain("rand");

    // Asynchronous reset in the middle of a fill with CPU writes queued.
    drv(0, '0, '0, 1, 15'h0400, 15'd20, 6'h09);
    drv(1, 15'h0650, 6'h01, 0, '0, '0, '0);
    drv(1, 15'h0651, 6'h02, 0, '0, '0, '0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_fb_we", fb_we, 0);
    chk("arst_fb_addr", fb_addr, 0);
    chk("arst_fb_data", fb_data, 0);
    chk("arst_fill_busy", fill_busy, 0);
    chk("arst_fill_done", fill_done, 0);
    chk("arst_cpu_ovf", cpu_ovf, 0);
    chk("arst_cpu_full", cpu_full, 0);
    @(negedge clk);
    rst_n = 1'b1;
    w0 = n_wr; d0 = n_done;
    repeat (10) @(negedge clk);
    chk("arst_no_writes", n_wr - w0, 0);
    chk("arst_no_done", n_done - d0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
